// File: rtl/uart_rx_core_if.sv
// Byte delivery handshake between the UART receiver (master) and its consumer (slave).
// rx_data/rx_valid flow out of the receiver, rx_ready flows back from the consumer.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 framing, or 8E1 when UART_PARITY_EN is defined; mid-bit sampling,
// one-entry holding register with valid/ready handshake and frame/parity/overrun pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_core_if.master rx,
  output logic           frame_err,
  output logic           overrun,
  output logic           parity_err,
  output logic           busy
);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             commit_q, commit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             rxs;
`ifdef UART_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign rxs = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], rxd};
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
`ifdef UART_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (rx_valid_q && rx.rx_ready) rx_valid_d = 1'b0;
    // shift_q cannot change in the cycle after the stop sample, so it is still the good byte
    if (commit_q) begin
      if (!rx_valid_q || rx.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (timer_q == HALF_END) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d        = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (timer_q == BIT_END) begin
          timer_d   = '0;
          par_bad_d = ^{shift_q, rxs};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start edge be caught without a gap
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           commit_d     = 1'b1;
`else
            commit_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        timer_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx.rx_data  = rx_data_q;
  assign rx.rx_valid = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
`ifdef UART_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
